// File: rtl/d8m_stream_pkg.sv
// Shared types and constants for the synthetic D8M pixel-stream generator.
package d8m_stream_pkg;

  typedef enum logic [1:0] {
    PAT_XRAMP = 2'd0,
    PAT_YRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_CONST = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    LINE,
    GAP
  } state_e;

  // Fibonacci LFSR taps 12,6,4,1 -> bit positions 11,5,3,0
  localparam logic [11:0] LFSR_SEED = 12'hACE;
  localparam logic [11:0] LFSR_TAPS = 12'h829;

  // Width of a counter spanning 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/d8m_pattern_gen.sv
// Test-pattern pixel source for d8m_stream_gen.
// Optional macro D8M_STREAM_GEN_LFSR_EN turns pattern 3 into a 12-bit LFSR.
module d8m_pattern_gen
  import d8m_stream_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  pat_e        pat_q,
  input  logic [11:0] const_q,
  input  logic        advance,
  input  logic        reseed,
  output logic [11:0] pixel
);

`ifdef D8M_STREAM_GEN_LFSR_EN
  logic [11:0] lfsr_q;
  logic        unused_const;

  assign unused_const = ^const_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      lfsr_q <= LFSR_SEED;
    end else if (reseed) begin
      lfsr_q <= LFSR_SEED;
    end else if (advance) begin
      lfsr_q <= {lfsr_q[10:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end
`else
  logic unused_lfsr_ports;

  assign unused_lfsr_ports = ^{iCLK, iRST, advance, reseed};
`endif

  always_comb begin
    pixel = '0;
    unique case (pat_q)
      PAT_XRAMP: pixel = x;
      PAT_YRAMP: pixel = y;
      PAT_CHECK: pixel = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
`ifdef D8M_STREAM_GEN_LFSR_EN
      PAT_CONST: pixel = lfsr_q;
`else
      PAT_CONST: pixel = const_q;
`endif
      default:   pixel = '0;
    endcase
  end

endmodule

// File: rtl/d8m_stream_gen.sv
// Synthetic D8M-style FVAL/LVAL/DATA transmitter with programmable geometry.
// Optional macro D8M_STREAM_GEN_LFSR_EN selects an LFSR for pattern 3.
module d8m_stream_gen
  import d8m_stream_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 152,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned FV_LEAD  = 44,
  parameter int unsigned V_GAP    = 1000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [1:0]  iPAT,
  input  logic [11:0] iCONST,
  output logic [11:0] oDATA,
  output logic        oFVAL,
  output logic        oLVAL,
  output logic [15:0] oFRAME_CNT,
  output logic        oBUSY
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned HW      = cnt_w(H_TOTAL);
  localparam int unsigned VW      = cnt_w(V_ACTIVE);
  localparam int unsigned PW      = cnt_w((FV_LEAD > V_GAP) ? FV_LEAD : V_GAP);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_ACTIVE - 1);
  localparam logic [PW-1:0] LEAD_LAST = PW'(FV_LEAD - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(V_GAP - 1);

  state_e        state_q, state_n;
  logic [HW-1:0] h_q, h_n;
  logic [VW-1:0] v_q, v_n;
  logic [PW-1:0] ph_q, ph_n;
  pat_e          pat_q;
  logic [11:0]   const_q;
  logic          latch;
  logic          frame_done;
  logic          fval_n;
  logic          lval_n;
  logic [11:0]   pixel;

  always_comb begin
    state_n    = state_q;
    h_n        = h_q;
    v_n        = v_q;
    ph_n       = ph_q;
    latch      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iEN) begin
          state_n = LEAD;
          ph_n    = '0;
          latch   = 1'b1;
        end
      end
      LEAD: begin
        if (ph_q == LEAD_LAST) begin
          state_n = LINE;
          h_n     = '0;
          v_n     = '0;
        end else begin
          ph_n = ph_q + 1'b1;
        end
      end
      LINE: begin
        if (h_q == H_LAST) begin
          h_n = '0;
          if (v_q == V_LAST) begin
            state_n    = GAP;
            ph_n       = '0;
            frame_done = 1'b1;
          end else begin
            v_n = v_q + 1'b1;
          end
        end else begin
          h_n = h_q + 1'b1;
        end
      end
      GAP: begin
        if (ph_q == GAP_LAST) begin
          if (iEN) begin
            state_n = LEAD;
            ph_n    = '0;
            latch   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          ph_n = ph_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Outputs are registered from next-state values so they align with the state
    fval_n = (state_n == LEAD) || (state_n == LINE);
    lval_n = (state_n == LINE) && (h_n < H_ACT);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      ph_q    <= '0;
      pat_q   <= PAT_XRAMP;
      const_q <= '0;
    end else begin
      state_q <= state_n;
      h_q     <= h_n;
      v_q     <= v_n;
      ph_q    <= ph_n;
      if (latch) begin
        pat_q   <= pat_e'(iPAT);
        const_q <= iCONST;
      end
    end
  end

  // pat_q is latched on LEAD entry, so it is already stable for every active pixel
  d8m_pattern_gen u_pattern (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .x       (12'(h_n)),
    .y       (12'(v_n)),
    .pat_q   (pat_q),
    .const_q (const_q),
    .advance (lval_n),
    .reseed  (latch),
    .pixel   (pixel)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDATA      <= '0;
      oFVAL      <= 1'b0;
      oLVAL      <= 1'b0;
      oFRAME_CNT <= '0;
      oBUSY      <= 1'b0;
    end else begin
      oDATA <= lval_n ? pixel : '0;
      oFVAL <= fval_n;
      oLVAL <= lval_n;
      oBUSY <= (state_n != IDLE);
      if (frame_done) begin
        oFRAME_CNT <= oFRAME_CNT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_d8m_stream_gen.sv
// Self-checking bench for d8m_stream_gen against a frame-position reference model.
module tb_d8m_stream_gen;

  localparam int HA     = 4;
  localparam int HB     = 3;
  localparam int VA     = 2;
  localparam int FL     = 2;
  localparam int VG     = 5;
  localparam int LP     = HA + HB;
  localparam int FV_END = FL + VA * LP;
  localparam int PER    = FV_END + VG;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iEN = 1'b0;
  logic [1:0]  iPAT = 2'd0;
  logic [11:0] iCONST = 12'd0;
  logic [11:0] oDATA;
  logic        oFVAL;
  logic        oLVAL;
  logic [15:0] oFRAME_CNT;
  logic        oBUSY;

  int nvec = 0;
  int nerr = 0;

  // Reference model: position within the frame period plus latched settings
  bit          m_act = 1'b0;
  int          m_k = 0;
  logic [1:0]  m_pat = 2'd0;
  logic [11:0] m_const = 12'd0;
  logic [15:0] m_cnt = 16'd0;
  logic [11:0] m_lfsr = 12'hACE;

  d8m_stream_gen #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_ACTIVE (VA),
    .FV_LEAD  (FL),
    .V_GAP    (VG)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iEN        (iEN),
    .iPAT       (iPAT),
    .iCONST     (iCONST),
    .oDATA      (oDATA),
    .oFVAL      (oFVAL),
    .oLVAL      (oLVAL),
    .oFRAME_CNT (oFRAME_CNT),
    .oBUSY      (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [11:0] lfsr_next(input logic [11:0] s);
    logic fb;
    fb = s[11] ^ s[5] ^ s[3] ^ s[0];
    return {s[10:0], fb};
  endfunction

  function automatic bit lval_at(input int k);
    return (k >= FL) && (k < FV_END) && (((k - FL) % LP) < HA);
  endfunction

  function automatic logic [11:0] pix_at(input int k);
    int x, y;
    x = (k - FL) % LP;
    y = (k - FL) / LP;
    case (m_pat)
      2'd0: return 12'(x);
      2'd1: return 12'(y);
      2'd2: return (((x / 8) + (y / 8)) % 2 == 1) ? 12'hFFF : 12'h000;
`ifdef D8M_STREAM_GEN_LFSR_EN
      default: return m_lfsr;
`else
      default: return m_const;
`endif
    endcase
  endfunction

  task automatic start_frame(input logic [1:0] p, input logic [11:0] c);
    m_act   = 1'b1;
    m_k     = 0;
    m_pat   = p;
    m_const = c;
    m_lfsr  = 12'hACE;
  endtask

  task automatic check(input string tag);
    logic        e_fval, e_lval, e_busy;
    logic [11:0] e_data;
    e_fval = m_act && (m_k < FV_END);
    e_lval = m_act && lval_at(m_k);
    e_data = e_lval ? pix_at(m_k) : 12'd0;
    e_busy = m_act;
    nvec++;
    assert (oFVAL === e_fval) else begin
      nerr++;
      $error("FAIL %s fval obs=%0b exp=%0b k=%0d", tag, oFVAL, e_fval, m_k);
    end
    nvec++;
    assert (oLVAL === e_lval) else begin
      nerr++;
      $error("FAIL %s lval obs=%0b exp=%0b k=%0d", tag, oLVAL, e_lval, m_k);
    end
    nvec++;
    assert (oDATA === e_data) else begin
      nerr++;
      $error("FAIL %s data obs=%h exp=%h k=%0d", tag, oDATA, e_data, m_k);
    end
    nvec++;
    assert (oFRAME_CNT === m_cnt) else begin
      nerr++;
      $error("FAIL %s frame_cnt obs=%h exp=%h", tag, oFRAME_CNT, m_cnt);
    end
    nvec++;
    assert (oBUSY === e_busy) else begin
      nerr++;
      $error("FAIL %s busy obs=%0b exp=%0b", tag, oBUSY, e_busy);
    end
  endtask

  task automatic tick(input string tag);
    logic        en;
    logic [1:0]  p;
    logic [11:0] c;
    en = iEN;
    p  = iPAT;
    c  = iCONST;
    @(posedge iCLK);
    if (m_act) begin
      if (lval_at(m_k)) m_lfsr = lfsr_next(m_lfsr);
      if (m_k == FV_END - 1) m_cnt = m_cnt + 16'd1;
      if (m_k == PER - 1) begin
        if (en) start_frame(p, c);
        else m_act = 1'b0;
      end else begin
        m_k++;
      end
    end else if (en) begin
      start_frame(p, c);
    end
    #1 check(tag);
  endtask

  task automatic model_reset();
    m_act  = 1'b0;
    m_k    = 0;
    m_cnt  = 16'd0;
    m_lfsr = 12'hACE;
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    model_reset();
    #1 check("reset_async");
    @(posedge iCLK);
    #1 check("reset_held");
    iRST = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit idle_seen;
    idle_seen = 1'b0;
    iEN = 1'b0;
    for (int i = 0; i < 3 * PER && !idle_seen; i++) begin
      tick(tag);
      if (!m_act) idle_seen = 1'b1;
    end
    nvec++;
    assert (idle_seen) else begin
      nerr++;
      $error("FAIL %s_timeout obs=busy exp=idle", tag);
    end
  endtask

  task automatic run_to_k(input int target, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 3 * PER && !hit; i++) begin
      tick(tag);
      if (m_act && m_k == target) hit = 1'b1;
    end
    nvec++;
    assert (hit) else begin
      nerr++;
      $error("FAIL %s_timeout obs=not_reached exp=k%0d", tag, target);
    end
  endtask

  initial begin
    int          fval_hi, lval_hi;
    logic [11:0] f0 [$];
    logic [11:0] f1 [$];

    do_reset();

    // Single frame, pattern 0, one-cycle enable pulse
    iPAT = 2'd0;
    iEN  = 1'b1;
    tick("single_start");
    iEN = 1'b0;
    fval_hi = int'(oFVAL);
    lval_hi = int'(oLVAL);
    for (int i = 0; i < PER + 3; i++) begin
      tick("single");
      fval_hi += int'(oFVAL);
      lval_hi += int'(oLVAL);
    end
    nvec++;
    assert (fval_hi === 16) else begin
      nerr++;
      $error("FAIL single_fval_len obs=%0d exp=16", fval_hi);
    end
    nvec++;
    assert (lval_hi === 8) else begin
      nerr++;
      $error("FAIL single_lval_len obs=%0d exp=8", lval_hi);
    end

    // Back-to-back frames, pattern 1
    iPAT = 2'd1;
    iEN  = 1'b1;
    for (int i = 0; i < 3 * PER; i++) tick("cont_yramp");
    drain("cont_drain");

    // Pattern change mid-frame is held off until the next latch
    iPAT   = 2'd2;
    iCONST = 12'h000;
    iEN    = 1'b1;
    run_to_k(FL + 1, "patchg_reach");
    iPAT   = 2'd3;
    iCONST = 12'h5A5;
    for (int i = 0; i < 2 * PER; i++) tick("patchg");
    drain("patchg_drain");

    // Asynchronous reset in the middle of a line
    iPAT = 2'd0;
    iEN  = 1'b1;
    run_to_k(FL + 2, "rst_reach");
    #2 iRST = 1'b1;
    model_reset();
    #1 check("rst_midline");
    @(negedge iCLK);
    iRST = 1'b0;
    for (int i = 0; i < PER + 1; i++) tick("post_rst");
    drain("post_rst_drain");

    // Frame counter wrap
    force dut.oFRAME_CNT = 16'hFFFF;
    m_cnt = 16'hFFFF;
    tick("wrap_forced");
    release dut.oFRAME_CNT;
    tick("wrap_released");
    iPAT = 2'd0;
    iEN  = 1'b1;
    tick("wrap_start");
    iEN = 1'b0;
    for (int i = 0; i < PER + 2; i++) tick("wrap");

    // Pattern 3 over two consecutive frames must repeat exactly
    iPAT   = 2'd3;
    iCONST = 12'h3C7;
    iEN    = 1'b1;
    for (int i = 0; i < 2 * PER; i++) begin
      tick("pat3");
      if (oLVAL && m_k >= FL) begin
        if (f0.size() < HA * VA) f0.push_back(oDATA);
        else f1.push_back(oDATA);
      end
    end
    nvec++;
    assert (f0.size() == HA * VA && f1.size() == HA * VA) else begin
      nerr++;
      $error("FAIL pat3_count obs=%0d/%0d exp=%0d", f0.size(), f1.size(), HA * VA);
    end
    for (int i = 0; i < HA * VA && i < f0.size() && i < f1.size(); i++) begin
      nvec++;
      assert (f0[i] === f1[i]) else begin
        nerr++;
        $error("FAIL pat3_repeat[%0d] obs=%h exp=%h", i, f1[i], f0[i]);
      end
    end
    drain("pat3_drain");

    // Randomized enable / pattern / constant traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) iEN = ~iEN;
      if ($urandom_range(0, 4) == 0) iPAT = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) iCONST = 12'($urandom);
      tick("random");
    end
    drain("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
